// File: rtl/if_fetch_ctrl_pkg.sv
// Shared LC-3b types used by the fetch stage: machine word, fetch FSM states,
// the "no redirect" PC-mux select and a small word-alignment helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } lc3b_fetch_state;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;

  function automatic lc3b_word align_word(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_target_sel.sv
// Combinational next-PC selection for the fetch stage: redirect detection,
// target alignment, and choice between target, pending target and pc+2.
module fetch_target_sel
  import lc3b_types::*;
(
  input  logic [1:0]      pcmux_sel,
  input  lc3b_word        br_addr,
  input  lc3b_word        pc,
  input  lc3b_word        pend_pc,
  input  lc3b_fetch_state state,
  output logic            redirect,
  output lc3b_word        target,
  output lc3b_word        next_pc
);

  always_comb begin
    redirect = (pcmux_sel != PCSEL_SEQ);
    target   = align_word(br_addr);
    // A live redirect always wins; SQUASH otherwise resumes at the remembered target.
    if (redirect) begin
      next_pc = target;
    end else if (state == SQUASH) begin
      next_pc = pend_pc;
    end else begin
      next_pc = pc + 16'd2;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// LC-3b instruction-fetch control: owns the fetch PC, runs the I-cache read
// handshake and squashes responses made stale by a redirect. Optional
// statistics counters are built when IF_FETCH_STATS_EN is defined.
//
// Handshake: icache_read is held high with a stable icache_address until the
// cycle icache_resp is seen; icache_rdata is sampled only in that cycle.
module if_fetch_ctrl
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_enable,
  input  logic [1:0]      pcmux_sel,
  input  lc3b_word        br_addr,
  input  logic            stall,
  input  logic            icache_resp,
  input  lc3b_word        icache_rdata,
  output logic            icache_read,
  output lc3b_word        icache_address,
  output logic            if_valid,
  output lc3b_word        if_instr,
  output lc3b_word        if_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output lc3b_word        stat_redirects,
  output lc3b_word        stat_squashes,
  output lc3b_fetch_state dbg_state
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        pend_pc_q, pend_pc_d;
  lc3b_word        if_instr_q, if_instr_d;
  lc3b_word        if_pc_q, if_pc_d;

  logic     redirect;
  lc3b_word target;
  lc3b_word next_pc;
  logic     req;
  logic     drop;

  fetch_target_sel u_target_sel (
    .pcmux_sel (pcmux_sel),
    .br_addr   (br_addr),
    .pc        (pc_q),
    .pend_pc   (pend_pc_q),
    .state     (state_q),
    .redirect  (redirect),
    .target    (target),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    req        = 1'b0;
    drop       = 1'b0;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (icache_resp) begin
          if (redirect) begin
            drop = 1'b1;
            pc_d = next_pc;
          end else begin
            if_instr_d = icache_rdata;
            if_pc_d    = pc_q;
            state_d    = HOLD;
          end
        end else if (redirect) begin
          // Request already in flight: remember the target, keep the address.
          pend_pc_d = target;
          state_d   = SQUASH;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      SQUASH: begin
        req = 1'b1;
        if (icache_resp) begin
          drop    = 1'b1;
          pc_d    = next_pc;
          state_d = FETCH;
        end else if (redirect) begin
          pend_pc_d = target;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 16'h0000;
      if_instr_q <= 16'h0000;
      if_pc_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign icache_read    = req && !rst;
  assign icache_address = pc_q;
  assign if_valid       = (state_q == HOLD) && !redirect && !rst;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign flush_if_id    = redirect;
  assign flush_id_ex    = redirect;
  assign dbg_state      = state_q;

`ifdef IF_FETCH_STATS_EN
  lc3b_word stat_redirects_q, stat_redirects_d;
  lc3b_word stat_squashes_q, stat_squashes_d;

  always_comb begin
    stat_redirects_d = stat_redirects_q;
    stat_squashes_d  = stat_squashes_q;
    if (redirect && branch_enable && (stat_redirects_q != 16'hFFFF)) begin
      stat_redirects_d = stat_redirects_q + 16'd1;
    end
    if (drop && (stat_squashes_q != 16'hFFFF)) begin
      stat_squashes_d = stat_squashes_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_redirects_q <= 16'h0000;
      stat_squashes_q  <= 16'h0000;
    end else begin
      stat_redirects_q <= stat_redirects_d;
      stat_squashes_q  <= stat_squashes_d;
    end
  end

  assign stat_redirects = stat_redirects_q;
  assign stat_squashes  = stat_squashes_q;
`else
  logic stats_unused;
  assign stats_unused   = branch_enable ^ drop;
  assign stat_redirects = 16'h0000;
  assign stat_squashes  = 16'h0000;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: sequential fetch, stall, redirects from
// HOLD/FETCH/SQUASH, PC wrap, reset mid-request and the optional counters.
module tb_if_fetch_ctrl;
  import lc3b_types::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            branch_enable;
  logic [1:0]      pcmux_sel;
  logic [15:0]     br_addr;
  logic            stall;
  logic            icache_resp;
  logic [15:0]     icache_rdata;
  logic            icache_read;
  logic [15:0]     icache_address;
  logic            if_valid;
  logic [15:0]     if_instr;
  logic [15:0]     if_pc;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic [15:0]     stat_redirects;
  logic [15:0]     stat_squashes;
  lc3b_fetch_state dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_redir;
  logic [15:0] exp_sq;

`ifdef IF_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_enable  (branch_enable),
    .pcmux_sel      (pcmux_sel),
    .br_addr        (br_addr),
    .stall          (stall),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .stat_redirects (stat_redirects),
    .stat_squashes  (stat_squashes),
    .dbg_state      (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Expected-counter model: one call per cycle a redirect / dropped resp is driven.
  task automatic note_redirect(input bit be);
    if (STATS && be) exp_redir = exp_redir + 16'd1;
  endtask

  task automatic note_drop;
    if (STATS) exp_sq = exp_sq + 16'd1;
  endtask

  task automatic do_reset;
    rst = 1'b1; pcmux_sel = 2'b01; br_addr = 16'h0000; branch_enable = 1'b1;
    stall = 1'b0; icache_resp = 1'b0; icache_rdata = 16'h0000;
    #1;
    checks++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin failures++; $display("FAIL rst_flush got=%b%b exp=11", flush_if_id, flush_id_ex); end
    checks++; if (icache_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", icache_read); end
    tick; tick;
    pcmux_sel = 2'b00; branch_enable = 1'b0; rst = 1'b0;
    exp_redir = 16'h0000; exp_sq = 16'h0000;
    #1;
  endtask

  // Issue one 1-cycle cache response in FETCH and check the HOLD-state output.
  task automatic fetch_one(input logic [15:0] addr, input logic [15:0] data);
    checks++; if (icache_read !== 1'b1 || icache_address !== addr) begin failures++; $display("FAIL fetch_req got=%b/%h exp=1/%h", icache_read, icache_address, addr); end
    icache_resp = 1'b1; icache_rdata = data;
    tick;
    icache_resp = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== addr || if_instr !== data) begin failures++; $display("FAIL fetch_out got=%b/%h/%h exp=1/%h/%h", if_valid, if_pc, if_instr, addr, data); end
    checks++; if (icache_read !== 1'b0) begin failures++; $display("FAIL fetch_hold_read got=%b exp=0", icache_read); end
  endtask

  task automatic check_stats(input string name);
    checks++; if (stat_redirects !== exp_redir || stat_squashes !== exp_sq) begin failures++; $display("FAIL %s_stats got=%h/%h exp=%h/%h", name, stat_redirects, stat_squashes, exp_redir, exp_sq); end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (icache_read !== 1'b1 || icache_address !== 16'h0000) begin failures++; $display("FAIL reset_req got=%b/%h exp=1/0000", icache_read, icache_address); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc !== 16'h0000) begin failures++; $display("FAIL reset_out got=%b/%h/%h exp=0/0000/0000", if_valid, if_instr, if_pc); end
    checks++; if (dbg_state !== FETCH || flush_if_id !== 1'b0) begin failures++; $display("FAIL reset_state got=%0d/%b exp=0/0", dbg_state, flush_if_id); end
    check_stats("reset");
  endtask

  task automatic test_sequential;
    do_reset;
    fetch_one(16'h0000, 16'h1111); tick;
    fetch_one(16'h0002, 16'h2222); tick;
    fetch_one(16'h0004, 16'h3333); tick;
    checks++; if (icache_address !== 16'h0006) begin failures++; $display("FAIL seq_next got=%h exp=0006", icache_address); end
  endtask

  task automatic test_stall;
    do_reset;
    fetch_one(16'h0000, 16'hA5A5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'hA5A5 || icache_read !== 1'b0) begin failures++; $display("FAIL stall_hold got=%b/%h/%h/%b exp=1/0000/a5a5/0", if_valid, if_pc, if_instr, icache_read); end
    end
    stall = 1'b0;
    tick;
    checks++; if (icache_read !== 1'b1 || icache_address !== 16'h0002) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/0002", icache_read, icache_address); end
  endtask

  task automatic test_redirect_hold;
    do_reset;
    fetch_one(16'h0000, 16'h1234);
    pcmux_sel = 2'b01; br_addr = 16'h3001; branch_enable = 1'b1; note_redirect(1'b1);
    #1;
    checks++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL hold_redir got=%b%b/%b exp=11/0", flush_if_id, flush_id_ex, if_valid); end
    tick;
    pcmux_sel = 2'b00; branch_enable = 1'b0; #1;
    checks++; if (icache_read !== 1'b1 || icache_address !== 16'h3000 || dbg_state !== FETCH) begin failures++; $display("FAIL hold_target got=%b/%h/%0d exp=1/3000/0", icache_read, icache_address, dbg_state); end
    fetch_one(16'h3000, 16'h5555);
    check_stats("hold_redir");
  endtask

  task automatic test_squash;
    do_reset;
    fetch_one(16'h0000, 16'h0101);
    pcmux_sel = 2'b11; br_addr = 16'h0006;
    tick;
    pcmux_sel = 2'b01; br_addr = 16'h4000; branch_enable = 1'b1; note_redirect(1'b1);
    #1;
    checks++; if (icache_read !== 1'b1 || icache_address !== 16'h0006 || flush_if_id !== 1'b1) begin failures++; $display("FAIL sq_start got=%b/%h/%b exp=1/0006/1", icache_read, icache_address, flush_if_id); end
    tick;
    pcmux_sel = 2'b00; branch_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (dbg_state !== SQUASH || icache_read !== 1'b1 || icache_address !== 16'h0006) begin failures++; $display("FAIL sq_wait got=%0d/%b/%h exp=2/1/0006", dbg_state, icache_read, icache_address); end
      tick;
    end
    icache_resp = 1'b1; icache_rdata = 16'hDEAD; note_drop;
    #1;
    checks++; if (icache_address !== 16'h0006 || if_valid !== 1'b0) begin failures++; $display("FAIL sq_resp got=%h/%b exp=0006/0", icache_address, if_valid); end
    tick;
    icache_resp = 1'b0; #1;
    checks++; if (dbg_state !== FETCH || icache_address !== 16'h4000 || if_valid !== 1'b0 || if_instr !== 16'h0101) begin failures++; $display("FAIL sq_after got=%0d/%h/%b/%h exp=0/4000/0/0101", dbg_state, icache_address, if_valid, if_instr); end
    check_stats("squash");
    fetch_one(16'h4000, 16'hBEEF);
  endtask

  task automatic test_double_squash;
    do_reset;
    pcmux_sel = 2'b01; br_addr = 16'h5000; branch_enable = 1'b1; note_redirect(1'b1);
    tick;
    br_addr = 16'h6000; note_redirect(1'b1); #1;
    checks++; if (dbg_state !== SQUASH || icache_address !== 16'h0000) begin failures++; $display("FAIL dbl_first got=%0d/%h exp=2/0000", dbg_state, icache_address); end
    tick;
    pcmux_sel = 2'b00; branch_enable = 1'b0; icache_resp = 1'b1; note_drop;
    tick;
    icache_resp = 1'b0; #1;
    checks++; if (dbg_state !== FETCH || icache_address !== 16'h6000) begin failures++; $display("FAIL dbl_target got=%0d/%h exp=0/6000", dbg_state, icache_address); end
    // Redirect arriving together with the stale response overrides the pending target.
    pcmux_sel = 2'b01; br_addr = 16'h7001;
    tick;
    br_addr = 16'h7101; icache_resp = 1'b1; note_drop;
    tick;
    pcmux_sel = 2'b00; icache_resp = 1'b0; #1;
    checks++; if (dbg_state !== FETCH || icache_address !== 16'h7100) begin failures++; $display("FAIL dbl_live got=%0d/%h exp=0/7100", dbg_state, icache_address); end
    check_stats("double");
  endtask

  task automatic test_coincident;
    do_reset;
    pcmux_sel = 2'b10; br_addr = 16'h2345; branch_enable = 1'b1;
    icache_resp = 1'b1; icache_rdata = 16'hFFFF; note_redirect(1'b1); note_drop;
    tick;
    pcmux_sel = 2'b00; branch_enable = 1'b0; icache_resp = 1'b0; #1;
    checks++; if (dbg_state !== FETCH || icache_address !== 16'h2344 || icache_read !== 1'b1) begin failures++; $display("FAIL coin_target got=%0d/%h/%b exp=0/2344/1", dbg_state, icache_address, icache_read); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc !== 16'h0000) begin failures++; $display("FAIL coin_drop got=%b/%h/%h exp=0/0000/0000", if_valid, if_instr, if_pc); end
    check_stats("coincident");
    fetch_one(16'h2344, 16'h4242);
  endtask

  task automatic test_wrap_and_reset;
    do_reset;
    fetch_one(16'h0000, 16'h0001);
    pcmux_sel = 2'b01; br_addr = 16'hFFFF;
    tick;
    pcmux_sel = 2'b00; #1;
    fetch_one(16'hFFFE, 16'h0F0F);
    tick;
    checks++; if (icache_address !== 16'h0000 || icache_read !== 1'b1) begin failures++; $display("FAIL wrap got=%h/%b exp=0000/1", icache_address, icache_read); end
    pcmux_sel = 2'b01; br_addr = 16'h8000;
    tick;
    pcmux_sel = 2'b00; #1;
    checks++; if (dbg_state !== SQUASH) begin failures++; $display("FAIL mid_squash got=%0d exp=2", dbg_state); end
    do_reset;
    checks++; if (dbg_state !== FETCH || icache_address !== 16'h0000 || icache_read !== 1'b1) begin failures++; $display("FAIL mid_reset got=%0d/%h/%b exp=0/0000/1", dbg_state, icache_address, icache_read); end
    icache_resp = 1'b1; icache_rdata = 16'h7777;
    tick;
    icache_resp = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h7777) begin failures++; $display("FAIL mid_refetch got=%b/%h/%h exp=1/0000/7777", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_redirect_hold;
    test_squash;
    test_double_squash;
    test_coincident;
    test_wrap_and_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch control stage of the LC-3b pipeline. It owns the architectural fetch PC, drives the instruction-cache read handshake, and presents fetched instructions to IF/ID. It consumes the EX-stage branch-resolution outputs (`branch_enable`, `br_addr`, `pcmux_sel`) to redirect fetch and to flush younger stages. A redirect issued while a cache read is still in flight is remembered: the stale response is squashed when it arrives, then the target is fetched.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `branch_enable`  in  1  EX branch-taken flag. Informational; qualifies the stats only.
- `pcmux_sel`  in  2  EX redirect select. `PCSEL_SEQ`=00 means no redirect; 01/10/11 mean redirect to `br_addr`.
- `br_addr`  in  16 (`lc3b_word`)  redirect target.
- `stall`  in  1  downstream hazard stall; IF/ID does not accept.
- `icache_resp`  in  1  cache read-complete strobe.
- `icache_rdata`  in  16  instruction word, valid with `icache_resp`.
- `icache_read`  out  1  read request; held high until `icache_resp`.
- `icache_address`  out  16  read address; stable while `icache_read` is high.
- `if_valid`  out  1  `if_instr` and `if_pc` hold a valid instruction.
- `if_instr`  out  16  captured instruction.
- `if_pc`  out  16  address of `if_instr`.
- `flush_if_id`, `flush_id_ex`  out  1  squash younger stages; both equal `redirect`.
- `stat_redirects`, `stat_squashes`  out  16  counters (see Configuration).

## Operation
- `redirect = (pcmux_sel != PCSEL_SEQ)`.
- Every target is aligned before use: `{br_addr[15:1],1'b0}`.

FSM:
- **FETCH**: `icache_read`=1, `icache_address`=pc.
  - resp and no redirect: capture `icache_rdata` into `if_instr` and pc into `if_pc`; go to HOLD.
  - resp and redirect: drop the data, pc<=target, stay in FETCH.
  - redirect, no resp: pend_pc<=target; go to SQUASH.
- **HOLD**: `if_valid` = !redirect.
  - redirect (wins over stall): pc<=target; go to FETCH.
  - !stall: pc<=pc+2, with 16-bit wrap (16'hFFFE→16'h0000); go to FETCH.
  - stall: hold all state.
- **SQUASH**: `icache_read`=1, `icache_address`=pc, which is the old, in-flight address.
  - redirect with no resp: pend_pc overwritten by the newest target.
  - resp: drop the data. pc<=target if redirect is asserted this cycle, else pend_pc. Go to FETCH.
- A redirect never deasserts `icache_read` or changes `icache_address` mid-request.
- `flush_*` are combinational from `redirect` in every state, including during `rst`.

## Timing
- Reset values: state=FETCH, pc=`RESET_PC`, pend_pc=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, counters=0.
- `icache_read`=0 while `rst` is high. It rises in the first cycle after reset.
- Reset asserted mid-request abandons the request. The cache must tolerate the read dropping.
- Latency: `if_valid` rises the cycle after `icache_resp`. Minimum rate is 1 instruction per 2 cycles plus cache latency (no prefetch).
- Redirect to the first target request:
  - HOLD, or FETCH with coincident resp: next cycle.
  - SQUASH: the cycle after the stale resp.
- `if_valid` drops combinationally in the cycle a redirect is seen in HOLD.

## Configuration
- `IF_FETCH_STATS_EN` defined:
  - `stat_redirects` increments on each cycle with redirect && `branch_enable`.
  - `stat_squashes` increments on each cycle that drops a resp (SQUASH, or FETCH with redirect).
  - Both counters saturate at 16'hFFFF and clear on `rst`.
- Undefined: the counters are not built; the stat ports are tied to 16'h0000.

## Structure
- `lc3b_types` additions: `lc3b_fetch_state` enum {FETCH, HOLD, SQUASH} and constant `PCSEL_SEQ`=2'b00. Reuse `lc3b_word`.
- One sub-module: `fetch_target_sel`, combinational. It performs redirect detection, target alignment, and the pc+2/target/pend_pc next-PC selection.

## Test plan
- Reset, then 1-cycle cache: addresses 0000, 0002, 0004 are issued; `if_valid` pulses with the matching `if_pc`.
- `stall`=1 for 3 cycles in HOLD: `if_instr`/`if_pc` are held and `icache_read`=0. On release, the next address is 0002.
- Redirect `pcmux_sel`=01, `br_addr`=3001 in HOLD: `flush_*`=1 that cycle, `if_valid`=0, next request is address 3000.
- Redirect to 4000 during a 4-cycle cache read of 0006: 0006 is held until resp, the data is dropped, next request is 4000, and `stat_squashes`=1 with `IF_FETCH_STATS_EN` defined.
- Two redirects in SQUASH (5000, then 6000) followed by resp: the next request is 6000.
- Redirect coincident with resp in FETCH: the data is dropped, the target is requested the next cycle, and no SQUASH state is entered.
